// File: rtl/offset_codec_stream.sv
// offset_codec_stream: keyed offset encode/decode over a
// two-stage valid/ready pipeline with a saturating word counter.
module offset_codec_stream #(
  parameter  int HALF_W = 4,
  parameter  int CNT_W  = 16,
  localparam int W      = 2*HALF_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_load,
  input  logic [W-1:0]      key_a,
  input  logic [W-1:0]      key_b,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [HALF_W-1:0] in_x,
  input  logic [HALF_W-1:0] in_y,
  input  logic [W-1:0]      in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_mode,
  output logic [W-1:0]      out_data,
  output logic [HALF_W-1:0] out_x,
  output logic [HALF_W-1:0] out_y,
  output logic              key_err,
  output logic [CNT_W-1:0]  word_cnt,
  input  logic              cnt_clr
);

  logic         s1_valid;
  logic         s1_mode;
  logic [W-1:0] s1_word;
  logic [W-1:0] s1_off;
  logic [W-1:0] a_reg;
  logic [W-1:0] b_reg;
  logic [W-1:0] res;
  logic         s1_load;
  logic         s2_load;
  logic         accept;
  logic         key_ok;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = !s1_valid || !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign key_ok   = key_load && !s1_valid && !out_valid && !accept;
  assign res      = s1_mode ? s1_word - s1_off : s1_word + s1_off;

  // S1: capture operand (inverted nibbles for encode) and A-B
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_word  <= '0;
      s1_off   <= '0;
    end else if (s1_load) begin
      s1_valid <= accept;
      if (accept) begin
        s1_mode <= in_mode;
        s1_word <= in_mode ? in_data : {~in_x, ~in_y};
        s1_off  <= a_reg - b_reg;
      end
    end
  end

  // S2: result register, held while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      out_data  <= '0;
      out_x     <= '0;
      out_y     <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_mode <= s1_mode;
        out_data <= res;
        out_x    <= s1_mode ? ~res[W-1:HALF_W] : '0;
        out_y    <= s1_mode ? ~res[HALF_W-1:0] : '0;
      end
    end
  end

  // Key registers: load only into an idle pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      key_err <= 1'b0;
    end else begin
      key_err <= key_load && !key_ok;
      if (key_ok) begin
        a_reg <= key_a;
        b_reg <= key_b;
      end
    end
  end

  // Saturating handshake counter, clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= '0;
    end else if (cnt_clr) begin
      word_cnt <= '0;
    end else if (out_valid && out_ready && !(&word_cnt)) begin
      word_cnt <= word_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_offset_codec_stream.sv
// tb_offset_codec_stream: directed literal checks plus a
// randomized run against a queue-based reference model.
module tb_offset_codec_stream;
  localparam int HW = 4;
  localparam int W  = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key_load = 1'b0;
  logic [W-1:0]  key_a = '0;
  logic [W-1:0]  key_b = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_mode = 1'b0;
  logic [HW-1:0] in_x = '0;
  logic [HW-1:0] in_y = '0;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_mode;
  logic [W-1:0]  out_data;
  logic [HW-1:0] out_x;
  logic [HW-1:0] out_y;
  logic          key_err;
  logic [CW-1:0] word_cnt;
  logic          cnt_clr = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  offset_codec_stream #(.HALF_W(HW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_load(key_load), .key_a(key_a), .key_b(key_b),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_x(in_x), .in_y(in_y),
    .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mode(out_mode), .out_data(out_data),
    .out_x(out_x), .out_y(out_y),
    .key_err(key_err), .word_cnt(word_cnt),
    .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic          mode;
    logic [W-1:0]  data;
    logic [HW-1:0] x;
    logic [HW-1:0] y;
    int            rdy;
  } item_t;

  item_t         q[$];
  logic [W-1:0]  ka = '0;
  logic [W-1:0]  kb = '0;
  logic [CW-1:0] mcnt = '0;
  logic          err_nxt = 1'b0;
  int            cyc = 0;

  function automatic item_t model(input logic m,
                                  input logic [HW-1:0] x,
                                  input logic [HW-1:0] y,
                                  input logic [W-1:0] d,
                                  input logic [W-1:0] a,
                                  input logic [W-1:0] b);
    item_t it;
    logic [W-1:0] c;
    it.mode = m;
    it.rdy  = 0;
    if (!m) begin
      c = {~x, ~y};
      it.data = c + a - b;
      it.x = '0;
      it.y = '0;
    end else begin
      it.data = d - a + b;
      it.x = ~it.data[W-1:HW];
      it.y = ~it.data[HW-1:0];
    end
    return it;
  endfunction

  // Per-cycle compare, then advance model to the next edge
  always @(negedge clk) begin
    logic  exp_rdy;
    logic  exp_ov;
    logic  acc;
    logic  hs;
    logic  kacc;
    item_t it;
    cyc++;
    if (!rst_n) begin
      q.delete();
      mcnt = '0;
      ka = '0;
      kb = '0;
      err_nxt = 1'b0;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_word_cnt", 32'(word_cnt), 0);
    end else begin
      exp_rdy = !(q.size() == 2 && !out_ready);
      exp_ov  = q.size() > 0 && cyc >= q[0].rdy;
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      if (out_valid && exp_ov) begin
        chk("out_data", 32'(out_data), 32'(q[0].data));
        chk("out_mode", 32'(out_mode), 32'(q[0].mode));
        chk("out_x", 32'(out_x), 32'(q[0].x));
        chk("out_y", 32'(out_y), 32'(q[0].y));
      end
      chk("key_err", 32'(key_err), 32'(err_nxt));
      chk("word_cnt", 32'(word_cnt), 32'(mcnt));
      acc  = in_valid && exp_rdy;
      hs   = exp_ov && out_ready;
      kacc = key_load && q.size() == 0 && !acc;
      err_nxt = key_load && !kacc;
      if (hs) begin
        void'(q.pop_front());
        if (q.size() > 0 && q[0].rdy < cyc + 1) q[0].rdy = cyc + 1;
      end
      if (acc) begin
        it = model(in_mode, in_x, in_y, in_data, ka, kb);
        it.rdy = cyc + 2;
        q.push_back(it);
      end
      if (cnt_clr) mcnt = '0;
      else if (hs && mcnt != '1) mcnt = mcnt + 1'b1;
      if (kacc) begin
        ka = key_a;
        kb = key_b;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic m, input logic [HW-1:0] x,
                      input logic [HW-1:0] y, input logic [W-1:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_mode = m;
    in_x = x;
    in_y = y;
    in_data = d;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load_keys(input logic [W-1:0] a, input logic [W-1:0] b);
    key_a = a;
    key_b = b;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  initial begin
    logic saw;
    repeat (3) tick();
    chk("rst_data", 32'(out_data), 0);
    chk("rst_xy", 32'({out_x, out_y}), 0);
    chk("rst_mode", 32'(out_mode), 0);
    chk("rst_err", 32'(key_err), 0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", 32'(in_ready), 1);

    load_keys(8'h10, 8'h03);
    send(1'b0, 4'h3, 4'h5, 8'h00);
    chk("enc_lat_early", 32'(out_valid), 0);
    tick();
    chk("enc_lat", 32'(out_valid), 1);
    chk("enc_data", 32'(out_data), 32'h0D7);
    chk("enc_xy", 32'({out_x, out_y}), 0);
    tick();
    send(1'b1, 4'h0, 4'h0, 8'hD7);
    tick();
    chk("dec_data", 32'(out_data), 32'h0CA);
    chk("dec_x", 32'(out_x), 3);
    chk("dec_y", 32'(out_y), 5);
    tick();

    load_keys(8'hFF, 8'h00);
    send(1'b0, 4'hF, 4'hF, 8'h00);
    tick();
    chk("wrap_enc", 32'(out_data), 32'h0FF);
    tick();
    send(1'b1, 4'h0, 4'h0, 8'h00);
    tick();
    chk("wrap_dec", 32'(out_data), 32'h001);
    chk("wrap_x", 32'(out_x), 32'hF);
    chk("wrap_y", 32'(out_y), 32'hE);
    tick();

    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_idle", 32'(word_cnt), 0);
    saw = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(1'b1, 4'h0, 4'h0, 8'(8'h20 + i));
      end
      begin
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          if (!in_ready) saw = 1'b1;
          tick();
        end
        out_ready = 1'b1;
      end
    join
    repeat (6) tick();
    chk("bp_stall_seen", 32'(saw), 1);
    chk("bp_cnt", 32'(word_cnt), 4);

    send(1'b0, 4'h3, 4'h5, 8'h00);
    load_keys(8'h10, 8'h03);
    chk("krej_err", 32'(key_err), 1);
    chk("krej_oldkey", 32'(out_data), 32'h0C9);
    tick();
    chk("krej_pulse", 32'(key_err), 0);
    repeat (3) tick();
    load_keys(8'h10, 8'h03);
    chk("kacc_noerr", 32'(key_err), 0);
    send(1'b0, 4'h3, 4'h5, 8'h00);
    tick();
    chk("kacc_newkey", 32'(out_data), 32'h0D7);
    chk("pre_clr_cnt", 32'(word_cnt != 0), 1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_wins", 32'(word_cnt), 0);
    repeat (2) tick();

    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_mode   = 1'($urandom);
      in_x      = 4'($urandom);
      in_y      = 4'($urandom);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      key_load  = ($urandom_range(0, 15) == 0);
      key_a     = 8'($urandom);
      key_b     = 8'($urandom);
      cnt_clr   = ($urandom_range(0, 49) == 0);
      tick();
    end
    in_valid = 1'b0;
    key_load = 1'b0;
    cnt_clr = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    chk("rand_drained", 32'(q.size()), 0);

    out_ready = 1'b0;
    send(1'b0, 4'h1, 4'h2, 8'h00);
    send(1'b0, 4'h4, 4'h6, 8'h00);
    chk("mid_pre_valid", 32'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_cnt", 32'(word_cnt), 0);
    chk("mid_rst_data", 32'(out_data), 0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("mid_ready", 32'(in_ready), 1);
    repeat (3) tick();
    chk("mid_no_ghost", 32'(out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
